// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC register, IF/ID pipeline latch and a RUN/WAIT/HALT control FSM.
// Optional hazard stall counter is built only when STALL_CNT_EN is defined.
module fetch_stage #(
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              hazard,
  input  logic              PC_update,
  input  logic [DATA_W-1:0] PC_target,
  input  logic [DATA_W-1:0] instr_mem_rd_data,
  output logic [DATA_W-1:0] instr_mem_addr,
  output logic [DATA_W-1:0] IF_ID_instr,
  output logic [DATA_W-1:0] IF_ID_PC_plus1,
  output logic              IF_ID_valid,
  output logic [3:0]        IF_ID_reg_rd,
  output logic [3:0]        IF_ID_reg_rs,
  output logic [3:0]        IF_ID_reg_rt,
  output logic              halted,
  output logic [DATA_W-1:0] stall_cnt
);

  localparam logic [3:0] OP_CALL = 4'b1101;
  localparam logic [3:0] OP_RET  = 4'b1110;
  localparam logic [3:0] OP_HLT  = 4'b1111;

  typedef enum logic [1:0] {ST_RUN, ST_WAIT, ST_HALT} state_t;

  state_t            state, state_nxt;
  logic [DATA_W-1:0] pc_p0, pc_nxt, pc_inc;
  logic [DATA_W-1:0] instr_p1, instr_nxt;
  logic [DATA_W-1:0] pcp1_p1, pcp1_nxt;
  logic              vld_p1, vld_nxt;
  logic [3:0]        fetch_op;

  function automatic logic [DATA_W-1:0] sat_inc(input logic [DATA_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  assign pc_inc   = pc_p0 + 1'b1;
  assign fetch_op = instr_mem_rd_data[DATA_W-1:DATA_W-4];

  always_comb begin
    state_nxt = state;
    pc_nxt    = pc_p0;
    instr_nxt = instr_p1;
    pcp1_nxt  = pcp1_p1;
    vld_nxt   = vld_p1;
    case (state)
      ST_RUN: begin
        if (PC_update) begin
          pc_nxt    = PC_target;
          instr_nxt = '0;
          pcp1_nxt  = '0;
          vld_nxt   = 1'b0;
        end else if (!hazard) begin
          pc_nxt    = pc_inc;
          instr_nxt = instr_mem_rd_data;
          pcp1_nxt  = pc_inc;
          vld_nxt   = 1'b1;
          if (fetch_op == OP_CALL || fetch_op == OP_RET)
            state_nxt = ST_WAIT;
          else if (fetch_op == OP_HLT)
            state_nxt = ST_HALT;
        end
      end
      ST_WAIT: begin
        if (PC_update) begin
          pc_nxt    = PC_target;
          instr_nxt = '0;
          pcp1_nxt  = '0;
          vld_nxt   = 1'b0;
          state_nxt = ST_RUN;
        end else if (!hazard) begin
          instr_nxt = '0;
          pcp1_nxt  = '0;
          vld_nxt   = 1'b0;
        end
      end
      ST_HALT: begin
        // Redirects are ignored here; only reset leaves HALT.
        if (!hazard) begin
          instr_nxt = '0;
          pcp1_nxt  = '0;
          vld_nxt   = 1'b0;
        end
      end
      default: state_nxt = ST_RUN;
    endcase
  end

  // Stage p0 -> p1: PC register and IF/ID latch
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_RUN;
      pc_p0    <= '0;
      instr_p1 <= '0;
      pcp1_p1  <= '0;
      vld_p1   <= 1'b0;
    end else begin
      state    <= state_nxt;
      pc_p0    <= pc_nxt;
      instr_p1 <= instr_nxt;
      pcp1_p1  <= pcp1_nxt;
      vld_p1   <= vld_nxt;
    end
  end

`ifdef STALL_CNT_EN
  logic [DATA_W-1:0] stall_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      stall_cnt_q <= '0;
    else if (hazard && !PC_update)
      stall_cnt_q <= sat_inc(stall_cnt_q);
  end

  assign stall_cnt = stall_cnt_q;
`else
  assign stall_cnt = '0;
`endif

  assign instr_mem_addr = pc_p0;
  assign IF_ID_instr    = instr_p1;
  assign IF_ID_PC_plus1 = pcp1_p1;
  assign IF_ID_valid    = vld_p1;
  assign IF_ID_reg_rd   = instr_p1[11:8];
  assign IF_ID_reg_rs   = instr_p1[7:4];
  assign IF_ID_reg_rt   = instr_p1[3:0];
  assign halted         = (state == ST_HALT);

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: sequential fetch, stalls, CALL/WAIT, redirect, wrap, HALT and async reset.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        hazard;
  logic        PC_update;
  logic [15:0] PC_target;
  logic [15:0] instr_mem_rd_data;
  logic [15:0] instr_mem_addr;
  logic [15:0] IF_ID_instr;
  logic [15:0] IF_ID_PC_plus1;
  logic        IF_ID_valid;
  logic [3:0]  IF_ID_reg_rd;
  logic [3:0]  IF_ID_reg_rs;
  logic [3:0]  IF_ID_reg_rt;
  logic        halted;
  logic [15:0] stall_cnt;

  logic [15:0] mem [0:511];
  int n_chk  = 0;
  int n_fail = 0;

`ifdef STALL_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  fetch_stage dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .hazard            (hazard),
    .PC_update         (PC_update),
    .PC_target         (PC_target),
    .instr_mem_rd_data (instr_mem_rd_data),
    .instr_mem_addr    (instr_mem_addr),
    .IF_ID_instr       (IF_ID_instr),
    .IF_ID_PC_plus1    (IF_ID_PC_plus1),
    .IF_ID_valid       (IF_ID_valid),
    .IF_ID_reg_rd      (IF_ID_reg_rd),
    .IF_ID_reg_rs      (IF_ID_reg_rs),
    .IF_ID_reg_rt      (IF_ID_reg_rt),
    .halted            (halted),
    .stall_cnt         (stall_cnt)
  );

  always #5 clk = ~clk;

  // Addresses outside the modelled window return a fixed non-zero filler word.
  always_comb begin
    instr_mem_rd_data = 16'h0A0A;
    if (instr_mem_addr < 16'd512) instr_mem_rd_data = mem[instr_mem_addr[8:0]];
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_ifid(input string tag, input logic [15:0] addr, input logic [15:0] ins,
                          input logic [15:0] pcp1, input logic vld);
    chk({tag, "_addr"},  instr_mem_addr, addr);
    chk({tag, "_instr"}, IF_ID_instr, ins);
    chk({tag, "_pcp1"},  IF_ID_PC_plus1, pcp1);
    chk({tag, "_valid"}, {15'd0, IF_ID_valid}, {15'd0, vld});
  endtask

  initial begin
    for (int i = 0; i < 512; i++) mem[i] = 16'h0000;
    mem[0]  = 16'h1123; mem[1] = 16'h2456; mem[2] = 16'h3789;
    mem[3]  = 16'h3000; mem[4] = 16'h4ABC;
    mem[5]  = 16'h0111; mem[6] = 16'h0222; mem[7] = 16'h0333;
    mem[8]  = 16'hD000;
    mem[64] = 16'h5555;
    mem[32] = 16'hF000;

    rst_n = 1'b0; hazard = 1'b0; PC_update = 1'b0; PC_target = 16'h0000;
    #1;
    chk_ifid("rst", 16'h0000, 16'h0000, 16'h0000, 1'b0);
    chk("rst_halted", {15'd0, halted}, 16'h0000);
    chk("rst_stall_cnt", stall_cnt, 16'h0000);
    #11 rst_n = 1'b1;

    // Sequential fetch with one-cycle latency
    step();
    chk_ifid("f0", 16'h0001, 16'h1123, 16'h0001, 1'b1);
    chk("f0_rd", {12'd0, IF_ID_reg_rd}, 16'h0001);
    chk("f0_rs", {12'd0, IF_ID_reg_rs}, 16'h0002);
    chk("f0_rt", {12'd0, IF_ID_reg_rt}, 16'h0003);
    step();
    chk_ifid("f1", 16'h0002, 16'h2456, 16'h0002, 1'b1);
    step();
    chk_ifid("f2", 16'h0003, 16'h3789, 16'h0003, 1'b1);
    step(); step();
    chk_ifid("f4", 16'h0005, 16'h4ABC, 16'h0005, 1'b1);

    // Three stall cycles at PC=5
    hazard = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk_ifid("stall", 16'h0005, 16'h4ABC, 16'h0005, 1'b1);
    end
    chk("stall_cnt3", stall_cnt, CNT_EN ? 16'd3 : 16'd0);
    hazard = 1'b0;

    // Run up to the CALL at address 8
    step(); step(); step();
    chk("pre_call_addr", instr_mem_addr, 16'h0008);
    step();
    chk_ifid("call", 16'h0009, 16'hD000, 16'h0009, 1'b1);
    step();
    chk_ifid("wait1", 16'h0009, 16'h0000, 16'h0000, 1'b0);
    step();
    chk_ifid("wait2", 16'h0009, 16'h0000, 16'h0000, 1'b0);
    PC_update = 1'b1; PC_target = 16'h0040;
    step();
    chk_ifid("redir", 16'h0040, 16'h0000, 16'h0000, 1'b0);
    PC_update = 1'b0;
    step();
    chk_ifid("after_redir", 16'h0041, 16'h5555, 16'h0041, 1'b1);

    // Redirect wins over a simultaneous hazard and does not count as a stall
    PC_update = 1'b1; hazard = 1'b1; PC_target = 16'h0100;
    step();
    chk_ifid("redir_haz", 16'h0100, 16'h0000, 16'h0000, 1'b0);
    chk("redir_haz_cnt", stall_cnt, CNT_EN ? 16'd3 : 16'd0);
    hazard = 1'b0; PC_target = 16'hFFFF;
    step();
    chk("to_ffff", instr_mem_addr, 16'hFFFF);
    PC_update = 1'b0;
    step();
    chk_ifid("wrap", 16'h0000, 16'h0A0A, 16'h0000, 1'b1);

    // HALT: PC frozen, redirect ignored
    PC_update = 1'b1; PC_target = 16'h0020;
    step();
    chk("to_hlt", instr_mem_addr, 16'h0020);
    PC_update = 1'b0;
    step();
    chk_ifid("hlt", 16'h0021, 16'hF000, 16'h0021, 1'b1);
    chk("hlt_halted", {15'd0, halted}, 16'h0001);
    step();
    chk_ifid("halt_bub", 16'h0021, 16'h0000, 16'h0000, 1'b0);
    PC_update = 1'b1; PC_target = 16'h0300;
    step();
    chk("halt_ign_addr", instr_mem_addr, 16'h0021);
    chk("halt_ign_halted", {15'd0, halted}, 16'h0001);
    PC_update = 1'b0; hazard = 1'b1;
    step();
    chk("halt_stall_cnt", stall_cnt, CNT_EN ? 16'd4 : 16'd0);
    hazard = 1'b0;

    // Asynchronous reset mid-cycle
    #2 rst_n = 1'b0;
    #1;
    chk_ifid("arst", 16'h0000, 16'h0000, 16'h0000, 1'b0);
    chk("arst_halted", {15'd0, halted}, 16'h0000);
    chk("arst_stall_cnt", stall_cnt, 16'h0000);
    #1 rst_n = 1'b1;
    step();
    chk_ifid("post_rst", 16'h0001, 16'h1123, 16'h0001, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
